regbank_reader: RTL and testbench

//  Read-side companion of the 8x8 register bank: fetches two operands (A, B) from R0..R7 per request, or streams
//  all eight registers out as a debug dump. Forwards a write landing in the bank on the same edge (write bypass).

---
 rtl/regbank_reader_pkg.sv | 19 +
 rtl/regbank_reader_regsel8.sv | 43 ++++
 rtl/regbank_reader.sv | 161 ++++++++++++++++
 tb/tb_regbank_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_reader_pkg.sv
// Shared definitions for the register bank read path: bank geometry, default width and FSM state encodings.
package regbank_reader_pkg;

  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 8;
  localparam int DEF_WIDTH = 8;

  localparam logic [REG_IDX_W-1:0] LAST_IDX = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } state_t;

  function automatic logic is_last_beat(input logic [REG_IDX_W-1:0] idx);
    return (idx == LAST_IDX);
  endfunction

endpackage

// File: rtl/regbank_reader_regsel8.sv
// Combinational 8:1 register select with optional forwarding of a same-edge bank write.
module regbank_reader_regsel8
  import regbank_reader_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter bit BYPASS = 1'b1
) (
  input  logic [WIDTH-1:0]     r0,
  input  logic [WIDTH-1:0]     r1,
  input  logic [WIDTH-1:0]     r2,
  input  logic [WIDTH-1:0]     r3,
  input  logic [WIDTH-1:0]     r4,
  input  logic [WIDTH-1:0]     r5,
  input  logic [WIDTH-1:0]     r6,
  input  logic [WIDTH-1:0]     r7,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [REG_IDX_W-1:0] wsel,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] sel,
  output logic [WIDTH-1:0]     dout
);

  // Forwarding makes the result equal to what the bank holds after the coming edge.
  always_comb begin
    dout = r0;
    if (BYPASS && we && (wsel == sel)) begin
      dout = wdata;
    end else begin
      case (sel)
        3'd0:    dout = r0;
        3'd1:    dout = r1;
        3'd2:    dout = r2;
        3'd3:    dout = r3;
        3'd4:    dout = r4;
        3'd5:    dout = r5;
        3'd6:    dout = r6;
        3'd7:    dout = r7;
        default: dout = r0;
      endcase
    end
  end

endmodule

// File: rtl/regbank_reader.sv
// Read-side companion of the 8x8 register bank: operand pair reads and 8-beat debug dumps through one
// registered response slot. State changes on the falling clock edge to line up with the bank.
module regbank_reader
  import regbank_reader_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [WIDTH-1:0]     R0,
  input  logic [WIDTH-1:0]     R1,
  input  logic [WIDTH-1:0]     R2,
  input  logic [WIDTH-1:0]     R3,
  input  logic [WIDTH-1:0]     R4,
  input  logic [WIDTH-1:0]     R5,
  input  logic [WIDTH-1:0]     R6,
  input  logic [WIDTH-1:0]     R7,
  input  logic [WIDTH-1:0]     WDATA,
  input  logic [REG_IDX_W-1:0] WSEL,
  input  logic                 WE,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic                 REQ_DUMP,
  input  logic [REG_IDX_W-1:0] SELA,
  input  logic [REG_IDX_W-1:0] SELB,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [WIDTH-1:0]     RSP_A,
  output logic [WIDTH-1:0]     RSP_B,
  output logic [REG_IDX_W-1:0] RSP_IDX,
  output logic                 RSP_LAST,
  output logic                 BUSY
);

  state_t                 state_r, state_nxt_s;
  logic [REG_IDX_W-1:0]   cnt_r, cnt_nxt_s;
  logic                   rsp_valid_r, rsp_valid_nxt_s;
  logic [WIDTH-1:0]       rsp_a_r, rsp_a_nxt_s;
  logic [WIDTH-1:0]       rsp_b_r, rsp_b_nxt_s;
  logic [REG_IDX_W-1:0]   rsp_idx_r, rsp_idx_nxt_s;
  logic                   rsp_last_r, rsp_last_nxt_s;
  logic [REG_IDX_W-1:0]   sel_a_s;
  logic [WIDTH-1:0]       rd_a_s, rd_b_s;
  logic                   slot_free_s;
  logic                   load_s;

  // Port A index: dump counter while dumping, beat 0 on a dump accept, SELA otherwise.
  always_comb begin
    sel_a_s = SELA;
    if (state_r == ST_DUMP) begin
      sel_a_s = cnt_r;
    end else if (REQ_DUMP) begin
      sel_a_s = 3'd0;
    end else begin
      sel_a_s = SELA;
    end
  end

  regbank_reader_regsel8 #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_sel_a (
    .r0(R0), .r1(R1), .r2(R2), .r3(R3), .r4(R4), .r5(R5), .r6(R6), .r7(R7),
    .wdata(WDATA), .wsel(WSEL), .we(WE), .sel(sel_a_s), .dout(rd_a_s)
  );

  regbank_reader_regsel8 #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_sel_b (
    .r0(R0), .r1(R1), .r2(R2), .r3(R3), .r4(R4), .r5(R5), .r6(R6), .r7(R7),
    .wdata(WDATA), .wsel(WSEL), .we(WE), .sel(SELB), .dout(rd_b_s)
  );

  assign slot_free_s = !rsp_valid_r || RSP_READY;
  assign REQ_READY   = RST_N && (state_r == ST_IDLE) && slot_free_s;
  assign BUSY        = RST_N && (state_r == ST_DUMP);
  assign RSP_VALID   = rsp_valid_r;
  assign RSP_A       = rsp_a_r;
  assign RSP_B       = rsp_b_r;
  assign RSP_IDX     = rsp_idx_r;
  assign RSP_LAST    = rsp_last_r;

  // Next-state, dump sequencing and response slot loading.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    load_s         = 1'b0;
    rsp_a_nxt_s    = rsp_a_r;
    rsp_b_nxt_s    = rsp_b_r;
    rsp_idx_nxt_s  = rsp_idx_r;
    rsp_last_nxt_s = rsp_last_r;
    case (state_r)
      ST_IDLE: begin
        if (REQ_VALID && slot_free_s) begin
          load_s      = 1'b1;
          rsp_a_nxt_s = rd_a_s;
          if (REQ_DUMP) begin
            rsp_b_nxt_s    = '0;
            rsp_idx_nxt_s  = 3'd0;
            rsp_last_nxt_s = 1'b0;
            cnt_nxt_s      = 3'd1;
            state_nxt_s    = ST_DUMP;
          end else begin
            rsp_b_nxt_s    = rd_b_s;
            rsp_idx_nxt_s  = SELA;
            rsp_last_nxt_s = 1'b1;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      ST_DUMP: begin
        if (slot_free_s) begin
          load_s         = 1'b1;
          rsp_a_nxt_s    = rd_a_s;
          rsp_b_nxt_s    = '0;
          rsp_idx_nxt_s  = cnt_r;
          rsp_last_nxt_s = is_last_beat(cnt_r);
          cnt_nxt_s      = cnt_r + 3'd1;
          if (is_last_beat(cnt_r)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DUMP;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
    // A load on the same edge as a pop keeps the slot valid with no bubble.
    if (load_s) begin
      rsp_valid_nxt_s = 1'b1;
    end else if (RSP_READY) begin
      rsp_valid_nxt_s = 1'b0;
    end else begin
      rsp_valid_nxt_s = rsp_valid_r;
    end
  end

  // State and response slot registers, falling edge with synchronous reset.
  always_ff @(negedge CLK) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      rsp_valid_r <= 1'b0;
      rsp_a_r     <= '0;
      rsp_b_r     <= '0;
      rsp_idx_r   <= 3'd0;
      rsp_last_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_a_r     <= rsp_a_nxt_s;
      rsp_b_r     <= rsp_b_nxt_s;
      rsp_idx_r   <= rsp_idx_nxt_s;
      rsp_last_r  <= rsp_last_nxt_s;
    end
  end

endmodule

// File: tb/tb_regbank_reader.sv
// Directed scoreboard bench for regbank_reader: expected beats are queued at request time and
// compared as the consumer takes each response; a BYPASS=0 copy runs in lockstep.
module tb_regbank_reader;

  logic       CLK;
  logic       RST_N;
  logic [7:0] bank [8];
  logic [7:0] WDATA;
  logic [2:0] WSEL;
  logic       WE;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_DUMP;
  logic [2:0] SELA;
  logic [2:0] SELB;
  logic       RSP_VALID;
  logic       RSP_READY;
  logic [7:0] RSP_A;
  logic [7:0] RSP_B;
  logic [2:0] RSP_IDX;
  logic       RSP_LAST;
  logic       BUSY;

  logic       req_ready_nb, rsp_valid_nb, rsp_last_nb, busy_nb;
  logic [7:0] rsp_a_nb, rsp_b_nb;
  logic [2:0] rsp_idx_nb;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int    n_vec = 0;
  int    n_miss = 0;
  int    n_pop = 0;

  regbank_reader #(.WIDTH(8), .BYPASS(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .R0(bank[0]), .R1(bank[1]), .R2(bank[2]), .R3(bank[3]),
    .R4(bank[4]), .R5(bank[5]), .R6(bank[6]), .R7(bank[7]),
    .WDATA(WDATA), .WSEL(WSEL), .WE(WE),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_DUMP(REQ_DUMP),
    .SELA(SELA), .SELB(SELB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_A(RSP_A), .RSP_B(RSP_B), .RSP_IDX(RSP_IDX), .RSP_LAST(RSP_LAST),
    .BUSY(BUSY)
  );

  regbank_reader #(.WIDTH(8), .BYPASS(1'b0)) dut_nb (
    .CLK(CLK), .RST_N(RST_N),
    .R0(bank[0]), .R1(bank[1]), .R2(bank[2]), .R3(bank[3]),
    .R4(bank[4]), .R5(bank[5]), .R6(bank[6]), .R7(bank[7]),
    .WDATA(WDATA), .WSEL(WSEL), .WE(WE),
    .REQ_VALID(REQ_VALID), .REQ_READY(req_ready_nb), .REQ_DUMP(REQ_DUMP),
    .SELA(SELA), .SELB(SELB),
    .RSP_VALID(rsp_valid_nb), .RSP_READY(RSP_READY),
    .RSP_A(rsp_a_nb), .RSP_B(rsp_b_nb), .RSP_IDX(rsp_idx_nb), .RSP_LAST(rsp_last_nb),
    .BUSY(busy_nb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [2:0] s);
    return (WE && (WSEL == s)) ? WDATA : bank[s];
  endfunction

  // One falling edge; the response being taken at that edge is popped and compared first.
  task automatic tick(output bit acc);
    beat_t e;
    #1;
    acc = REQ_VALID && REQ_READY;
    if (RSP_VALID && RSP_READY) begin
      chk("rsp_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_a", RSP_A, e.a);
        chk("rsp_b", RSP_B, e.b);
        chk("rsp_idx", RSP_IDX, e.idx);
        chk("rsp_last", RSP_LAST, e.last);
        n_pop++;
      end
    end
    @(negedge CLK);
    @(posedge CLK);
    #1;
  endtask

  task automatic step();
    bit dummy;
    tick(dummy);
  endtask

  task automatic issue_read(input logic [2:0] a, input logic [2:0] b);
    bit acc;
    acc = 1'b0;
    SELA = a; SELB = b; REQ_DUMP = 1'b0; REQ_VALID = 1'b1;
    sb.push_back('{a: rd(a), b: rd(b), idx: a, last: 1'b1});
    for (int i = 0; i < 20; i++) begin
      tick(acc);
      if (acc) break;
    end
    chk("read_accepted", 32'(acc), 32'd1);
    REQ_VALID = 1'b0;
  endtask

  task automatic push_dump();
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{a: bank[i], b: 8'h00, idx: 3'(i), last: (i == 7)});
    end
  endtask

  initial begin
    bit acc;
    int start_pop;
    bit hit;
    RST_N = 1'b0; WDATA = 8'h00; WSEL = 3'd0; WE = 1'b0;
    REQ_VALID = 1'b0; REQ_DUMP = 1'b0; SELA = 3'd0; SELB = 3'd0; RSP_READY = 1'b0;
    for (int i = 0; i < 8; i++) bank[i] = 8'h00;

    // Reset, then reset held for two edges during a stalled dump
    step(); step();
    RST_N = 1'b1;
    step();
    chk("idle_req_ready", REQ_READY, 1'b1);
    chk("idle_busy", BUSY, 1'b0);
    chk("idle_valid", RSP_VALID, 1'b0);
    for (int i = 0; i < 8; i++) bank[i] = {4'(i), 4'h1};
    REQ_VALID = 1'b1; REQ_DUMP = 1'b1;
    tick(acc);
    chk("dump0_accept", 32'(acc), 32'd1);
    chk("dump0_busy", BUSY, 1'b1);
    chk("dump0_valid", RSP_VALID, 1'b1);
    chk("dump0_a", RSP_A, 8'h01);
    RST_N = 1'b0;
    step(); step();
    chk("rst_valid", RSP_VALID, 1'b0);
    chk("rst_a", RSP_A, 8'h00);
    chk("rst_b", RSP_B, 8'h00);
    chk("rst_idx", RSP_IDX, 3'd0);
    chk("rst_last", RSP_LAST, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_req_ready", REQ_READY, 1'b0);
    REQ_VALID = 1'b0; REQ_DUMP = 1'b0; RST_N = 1'b1;
    step();
    chk("rel_busy", BUSY, 1'b0);
    chk("rel_req_ready", REQ_READY, 1'b1);

    // Normal read, one-edge latency
    for (int i = 0; i < 8; i++) bank[i] = 8'h00;
    bank[3] = 8'h5A; bank[6] = 8'hC3; RSP_READY = 1'b1;
    issue_read(3'd3, 3'd6);
    chk("read_valid", RSP_VALID, 1'b1);
    chk("read_a_direct", RSP_A, 8'h5A);
    step();

    // Write bypass versus no bypass
    bank[2] = 8'h11; WE = 1'b1; WSEL = 3'd2; WDATA = 8'hEE;
    issue_read(3'd2, 3'd2);
    chk("bypass_a", RSP_A, 8'hEE);
    chk("nobypass_a", rsp_a_nb, 8'h11);
    bank[2] = 8'hEE; WE = 1'b0;
    step();

    // Backpressure with a request pending
    RSP_READY = 1'b0;
    issue_read(3'd3, 3'd6);
    SELA = 3'd6; SELB = 3'd3; REQ_VALID = 1'b1;
    sb.push_back('{a: 8'hC3, b: 8'h5A, idx: 3'd6, last: 1'b1});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", RSP_VALID, 1'b1);
      chk("stall_a", RSP_A, 8'h5A);
      chk("stall_b", RSP_B, 8'hC3);
      chk("stall_idx", RSP_IDX, 3'd3);
      chk("stall_req_ready", REQ_READY, 1'b0);
    end
    RSP_READY = 1'b1;
    tick(acc);
    chk("unstall_accept", 32'(acc), 32'd1);
    chk("no_bubble", RSP_VALID, 1'b1);
    REQ_VALID = 1'b0;
    step();
    chk("drained_valid", RSP_VALID, 1'b0);

    // Full dump with the consumer toggling ready every edge
    for (int i = 0; i < 8; i++) bank[i] = {4'(i), 4'h1};
    REQ_VALID = 1'b1; REQ_DUMP = 1'b1;
    push_dump();
    start_pop = n_pop;
    tick(acc);
    chk("dump_accept", 32'(acc), 32'd1);
    REQ_VALID = 1'b0; REQ_DUMP = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      RSP_READY = ~RSP_READY;
      step();
      chk("dump_busy", BUSY, ((n_pop - start_pop) + int'(RSP_VALID)) < 8);
    end
    chk("dump_all_beats", 32'(sb.size()), 32'd0);
    chk("dump_done_busy", BUSY, 1'b0);

    // Reset after beat 4 aborts the dump
    RSP_READY = 1'b1; REQ_VALID = 1'b1; REQ_DUMP = 1'b1;
    push_dump();
    tick(acc);
    chk("dump2_accept", 32'(acc), 32'd1);
    REQ_VALID = 1'b0; REQ_DUMP = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (RSP_VALID && (RSP_IDX == 3'd4)) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    chk("reached_beat4", 32'(hit), 32'd1);
    RST_N = 1'b0;
    step();
    sb.delete();
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_valid", RSP_VALID, 1'b0);
      chk("abort_busy", BUSY, 1'b0);
    end
    issue_read(3'd0, 3'd7);
    chk("post_a", RSP_A, 8'h01);
    chk("post_b", RSP_B, 8'h71);
    step();
    chk("final_queue", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
